// File: rtl/exe_pkg.sv
// Shared types for the execution-unit result buffer: opcode enum, status width and the stored entry layout.
// Result width follows EXE_RESULT_WIDTH (default 32) so the struct and the buffer's WIDTH stay in step.
`ifndef EXE_RESULT_WIDTH
`define EXE_RESULT_WIDTH 32
`endif

package exe_pkg;

    localparam int RESULT_W = `EXE_RESULT_WIDTH;
    localparam int STATUS_W = 5;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_CMP  = 2'b01,
        OP_SET  = 2'b10,
        OP_CONV = 2'b11
    } oper_t;

    typedef struct packed {
        oper_t                oper;
        logic [STATUS_W-1:0]  status;
        logic [RESULT_W-1:0]  result;
    } exe_entry_t;

endpackage

// File: rtl/exe_rb_fifo.sv
// Generic DEPTH x W register-array FIFO; pointers carry an extra wrap bit so full and empty never alias.
// Reads are combinational from the head slot and read as zero while empty.
module exe_rb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wrPtr_q, wrPtr_d;
    logic [AW:0]  rdPtr_q, rdPtr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         doPush, doPop;

    assign count_o = wrPtr_q - rdPtr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage is deliberately left out of reset; empty reads are masked instead.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/exe_result_buffer.sv
// Result buffer after the execution unit: FIFO of {oper,status,result} plus sticky status accumulation.
// Define EXE_RESULT_BUFFER_STATS_EN to add saturating accept/drop counters.
module exe_result_buffer
    import exe_pkg::*;
#(
    parameter int WIDTH = RESULT_W,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_result,
    input  logic [STATUS_W-1:0]        i_status,
    input  logic [1:0]                 i_oper,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_result,
    output logic [STATUS_W-1:0]        o_status,
    output logic [1:0]                 o_oper,
    output logic [$clog2(DEPTH):0]     o_count,
    input  logic                       i_clear_sticky,
    output logic [STATUS_W-1:0]        o_sticky
`ifdef EXE_RESULT_BUFFER_STATS_EN
    ,
    output logic [15:0]                o_accept_cnt,
    output logic [15:0]                o_drop_cnt
`endif
);

    exe_entry_t          wrEntry, rdEntry;
    logic                full, empty, push;
    logic [STATUS_W-1:0] sticky_q, sticky_d;

    assign wrEntry = '{oper: oper_t'(i_oper), status: i_status, result: i_result};

    exe_rb_fifo #(
        .W     ($bits(exe_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (i_valid),
        .pop_i   (i_ready),
        .data_i  (wrEntry),
        .data_o  (rdEntry),
        .count_o (o_count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign o_ready  = !full;
    assign o_valid  = !empty;
    assign push     = i_valid && o_ready;
    assign o_result = rdEntry.result;
    assign o_status = rdEntry.status;
    assign o_oper   = rdEntry.oper;
    assign o_sticky = sticky_q;

    // A clear coinciding with a push restarts accumulation from that push's status.
    always_comb begin
        sticky_d = sticky_q;
        if (i_clear_sticky && push) sticky_d = i_status;
        else if (i_clear_sticky)    sticky_d = '0;
        else if (push)              sticky_d = sticky_q | i_status;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sticky_q <= '0;
        else          sticky_q <= sticky_d;
    end

`ifdef EXE_RESULT_BUFFER_STATS_EN
    logic [15:0] acceptCnt_q, dropCnt_q;
    logic        drop;

    assign drop         = i_valid && !o_ready;
    assign o_accept_cnt = acceptCnt_q;
    assign o_drop_cnt   = dropCnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acceptCnt_q <= '0;
            dropCnt_q   <= '0;
        end else if (i_clear_sticky) begin
            acceptCnt_q <= '0;
            dropCnt_q   <= '0;
        end else begin
            if (push && acceptCnt_q != 16'hFFFF) acceptCnt_q <= acceptCnt_q + 16'd1;
            if (drop && dropCnt_q != 16'hFFFF)   dropCnt_q   <= dropCnt_q + 16'd1;
        end
    end
`endif

endmodule
